vproc_mem_model: RTL and testbench

// - Synthesizable single-port behavioural memory that sits directly downstream of vproc_top's

---
 rtl/vproc_mem_model.sv | 137 +++++++++++++
 tb/tb_vproc_mem_model.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_mem_model.sv
// vproc_mem_model
//   Single-port behavioural memory for the vproc unified memory port.
//   Every request is accepted and answered after MEM_LATENCY cycles.
//   Writes honour byte enables. Addresses above the array give an error response.
//   A small FSM detects the program-end request and counts run cycles.
//   Benches preload the array through the hierarchical path <inst>.mem_q.
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   mem_req                request valid (no grant; always accepted)
//   mem_addr               byte address, bits [1:0] ignored
//   mem_we, mem_be         write strobe, per-byte write enables
//   mem_wdata              write data
//   mem_rvalid             response valid (reads and writes)
//   mem_err                response is an out-of-range error
//   mem_rdata              read data (0 for errors and write responses)
//   done                   program end reached, sticky until reset
//   run_cycles             cycles from first request to end request, inclusive
//
// state | meaning
// IDLE  | no non-end request seen yet
// RUN   | program running, run_cycles counting
// DONE  | end request seen, run_cycles frozen
module vproc_mem_model #(
  parameter int unsigned MEM_SZ      = 262144,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] END_ADDR    = 32'h0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req,
  input  logic [31:0]      mem_addr,
  input  logic             mem_we,
  input  logic [3:0]       mem_be,
  input  logic [31:0]      mem_wdata,
  output logic             mem_rvalid,
  output logic             mem_err,
  output logic [31:0]      mem_rdata,
  output logic             done,
  output logic [CNT_W-1:0] run_cycles
);

  localparam int unsigned AW    = $clog2(MEM_SZ);
  localparam int unsigned WORDS = MEM_SZ / 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [31:0] mem_q [WORDS];

  logic [AW-3:0] idx;
  logic          oor;
  logic [31:0]   rdata_s0;
  logic          unused_addr_lsb;

  assign idx             = mem_addr[AW-1:2];
  assign oor             = |mem_addr[31:AW];
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Combinational array read: the response register captures the value
  // present before any write landing on the same edge.
  assign rdata_s0 = (mem_req && !mem_we && !oor) ? mem_q[idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (mem_req && mem_we && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  logic        vld_q [MEM_LATENCY];
  logic        err_q [MEM_LATENCY];
  logic [31:0] dat_q [MEM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= 32'h0;
      end
    end else begin
      vld_q[0] <= mem_req;
      err_q[0] <= mem_req && oor;
      dat_q[0] <= rdata_s0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign mem_rvalid = vld_q[MEM_LATENCY-1];
  assign mem_err    = err_q[MEM_LATENCY-1];
  assign mem_rdata  = dat_q[MEM_LATENCY-1];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_end;

  assign is_end = mem_req && (mem_addr == END_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // An end request before the program starts is served but not tracked.
        if (mem_req && !is_end) begin
          state_d = RUN;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (is_end) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign done       = (state_q == DONE);
  assign run_cycles = cnt_q;

endmodule

// File: tb/tb_vproc_mem_model.sv
module tb_vproc_mem_model;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;

  logic        rv1, er1, dn1;
  logic [31:0] rd1, rc1;
  logic        rv3, er3, dn3;
  logic [31:0] rd3, rc3;
  logic        rv4, er4, dn4;
  logic [31:0] rd4, rc4;
  logic        rvs, ers, dns;
  logic [31:0] rds;
  logic [2:0]  rcs;

  int checks = 0;
  int errors = 0;

  vproc_mem_model #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(rv1), .mem_err(er1),
    .mem_rdata(rd1), .done(dn1), .run_cycles(rc1));

  vproc_mem_model #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(rv3), .mem_err(er3),
    .mem_rdata(rd3), .done(dn3), .run_cycles(rc3));

  vproc_mem_model #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(rv4), .mem_err(er4),
    .mem_rdata(rd4), .done(dn4), .run_cycles(rc4));

  // Narrow counter instance to exercise saturation.
  vproc_mem_model #(.MEM_SZ(1024), .MEM_LATENCY(1), .CNT_W(3)) duts (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(rvs), .mem_err(ers),
    .mem_rdata(rds), .done(dns), .run_cycles(rcs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One request for exactly one edge; returns 1 time unit after that edge.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_be    = be;
    mem_wdata = wd;
    @(posedge clk);
    #1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b exp 0", rv1); end
    checks++; if (er1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", er1); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rd1); end
    checks++; if (dn1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", dn1); end
    checks++; if (rc1 !== 32'h0) begin errors++; $display("FAIL reset_run_cycles: got %0d exp 0", rc1); end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_write_read;
    drive(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL wr_rvalid: got %0b exp 1", rv1); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h exp 0", rd1); end
    drive(1'b0, 32'h100, 4'h0, 32'h0);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %0b exp 1", rv1); end
    checks++; if (er1 !== 1'b0) begin errors++; $display("FAIL rd_err: got %0b exp 0", er1); end
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h exp deadbeef", rd1); end
    idle(1);
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop: got %0b exp 0", rv1); end
  endtask

  task automatic test_byte_enable;
    drive(1'b1, 32'h200, 4'hF, 32'h11223344);
    drive(1'b1, 32'h200, 4'b0101, 32'hAABBCCDD);
    drive(1'b0, 32'h200, 4'h0, 32'h0);
    checks++; if (rd1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_rdata: got %h exp 11bb33dd", rd1); end
    drive(1'b1, 32'h200, 4'b0000, 32'hFFFFFFFF);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL be0_rvalid: got %0b exp 1", rv1); end
    drive(1'b0, 32'h200, 4'h0, 32'h0);
    checks++; if (rd1 !== 32'h11BB33DD) begin errors++; $display("FAIL be0_rdata: got %h exp 11bb33dd", rd1); end
  endtask

  task automatic test_range;
    drive(1'b1, 32'h4, 4'hF, 32'h12345678);
    drive(1'b0, 32'h00040000, 4'h0, 32'h0);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL oor_rd_rvalid: got %0b exp 1", rv1); end
    checks++; if (er1 !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %0b exp 1", er1); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL oor_rd_rdata: got %h exp 0", rd1); end
    drive(1'b1, 32'h00040004, 4'hF, 32'h55555555);
    checks++; if (er1 !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %0b exp 1", er1); end
    drive(1'b0, 32'h4, 4'h0, 32'h0);
    checks++; if (er1 !== 1'b0) begin errors++; $display("FAIL alias_err: got %0b exp 0", er1); end
    checks++; if (rd1 !== 32'h12345678) begin errors++; $display("FAIL alias_rdata: got %h exp 12345678", rd1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [3];
    logic        exp_v;
    exp_d[0] = 32'hA0A0A0A0;
    exp_d[1] = 32'hB1B1B1B1;
    exp_d[2] = 32'hC2C2C2C2;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(4*i), 4'hF, exp_d[i]);
    idle(5);
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'(4*c);
      end else begin
        mem_req  = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_v = (c >= 2) && (c <= 4);
      checks++; if (rv3 !== exp_v) begin errors++; $display("FAIL lat3_rvalid c%0d: got %0b exp %0b", c, rv3, exp_v); end
      if (exp_v) begin
        checks++; if (rd3 !== exp_d[c-2]) begin errors++; $display("FAIL lat3_rdata c%0d: got %h exp %h", c, rd3, exp_d[c-2]); end
        checks++; if (er3 !== 1'b0) begin errors++; $display("FAIL lat3_err c%0d: got %0b exp 0", c, er3); end
      end
    end
    mem_req = 1'b0;
  endtask

  task automatic test_fsm;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (dn1 !== 1'b0) begin errors++; $display("FAIL fsm_idle_end_done: got %0b exp 0", dn1); end
    checks++; if (rc1 !== 32'd0) begin errors++; $display("FAIL fsm_idle_end_cnt: got %0d exp 0", rc1); end
    drive(1'b0, 32'h80, 4'h0, 32'h0);
    checks++; if (rc1 !== 32'd1) begin errors++; $display("FAIL fsm_start_cnt: got %0d exp 1", rc1); end
    idle(4);
    checks++; if (rc1 !== 32'd5) begin errors++; $display("FAIL fsm_mid_cnt: got %0d exp 5", rc1); end
    idle(4);
    checks++; if (dn1 !== 1'b0) begin errors++; $display("FAIL fsm_pre_end_done: got %0b exp 0", dn1); end
    checks++; if (rc1 !== 32'd9) begin errors++; $display("FAIL fsm_pre_end_cnt: got %0d exp 9", rc1); end
    drive(1'b0, 32'h0, 4'h0, 32'h0);
    checks++; if (dn1 !== 1'b1) begin errors++; $display("FAIL fsm_done: got %0b exp 1", dn1); end
    checks++; if (rc1 !== 32'd10) begin errors++; $display("FAIL fsm_end_cnt: got %0d exp 10", rc1); end
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL fsm_end_rvalid: got %0b exp 1", rv1); end
    checks++; if (dns !== 1'b1) begin errors++; $display("FAIL fsm_sat_done: got %0b exp 1", dns); end
    checks++; if (rcs !== 3'd7) begin errors++; $display("FAIL fsm_sat_cnt: got %0d exp 7", rcs); end
    drive(1'b1, 32'h80, 4'hF, 32'h0);
    drive(1'b0, 32'h84, 4'h0, 32'h0);
    idle(3);
    checks++; if (dn1 !== 1'b1) begin errors++; $display("FAIL fsm_done_hold: got %0b exp 1", dn1); end
    checks++; if (rc1 !== 32'd10) begin errors++; $display("FAIL fsm_cnt_frozen: got %0d exp 10", rc1); end
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 32'h300, 4'hF, 32'hCAFEF00D);
    idle(6);
    checks++; if (dn4 !== 1'b1) begin errors++; $display("FAIL mf_pre_done: got %0b exp 1", dn4); end
    drive(1'b0, 32'h300, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL mf_rst_rvalid: got %0b exp 0", rv4); end
    checks++; if (dn4 !== 1'b0) begin errors++; $display("FAIL mf_rst_done: got %0b exp 0", dn4); end
    checks++; if (rc4 !== 32'd0) begin errors++; $display("FAIL mf_rst_cnt: got %0d exp 0", rc4); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL mf_post_rvalid c%0d: got %0b exp 0", c, rv4); end
    end
    checks++; if (dn4 !== 1'b0) begin errors++; $display("FAIL mf_post_done: got %0b exp 0", dn4); end
    checks++; if (rc4 !== 32'd0) begin errors++; $display("FAIL mf_post_cnt: got %0d exp 0", rc4); end
    drive(1'b0, 32'h300, 4'h0, 32'h0);
    idle(2);
    checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL mf_lat4_early: got %0b exp 0", rv4); end
    idle(1);
    checks++; if (rv4 !== 1'b1) begin errors++; $display("FAIL mf_lat4_rvalid: got %0b exp 1", rv4); end
    checks++; if (rd4 !== 32'hCAFEF00D) begin errors++; $display("FAIL mf_retained: got %h exp cafef00d", rd4); end
  endtask

  initial begin
    rst       = 1'b1;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_range();
    test_back_to_back();
    test_fsm();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
